// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around a registered 32-bit ALU: request FIFO, credit-gated issue,
// two-stage tag pipe and response FIFO. Define ALU_ISSUE_STATS_EN to add stat_issued/stat_stall.
module alu_issue_ctrl #(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 4,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stall
`endif
);
    localparam int REQ_AW = $clog2(REQ_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam int REQ_W  = 3 + 2 * WIDTH + TAG_W;
    localparam int RSP_W  = WIDTH + TAG_W;
    localparam int CRD_W  = RSP_AW + 2;

    // ---------------- request FIFO ----------------
    logic [REQ_W-1:0]  r_req_mem [REQ_DEPTH];
    logic [REQ_AW-1:0] r_req_wptr, r_req_rptr;
    logic [REQ_AW:0]   r_req_count;
    logic              w_req_full, w_req_empty, w_req_push, w_req_pop;
    logic [REQ_W-1:0]  w_req_head;
    logic              w_issue;

    assign w_req_full  = (r_req_count == (REQ_AW + 1)'(REQ_DEPTH));
    assign w_req_empty = (r_req_count == '0);
    // A pop on a full FIFO deliberately does not open req_ready in the same cycle.
    assign req_ready   = rst_n && !w_req_full;
    assign w_req_push  = req_valid && req_ready;
    assign w_req_pop   = w_issue;
    assign w_req_head  = r_req_mem[r_req_rptr];

    // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_req_push) r_req_mem[r_req_wptr] <= {req_op, req_a, req_b, req_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_wptr  <= '0;
            r_req_rptr  <= '0;
            r_req_count <= '0;
        end else begin
            if (w_req_push) r_req_wptr <= r_req_wptr + REQ_AW'(1);
            if (w_req_pop)  r_req_rptr <= r_req_rptr + REQ_AW'(1);
            case ({w_req_push, w_req_pop})
                2'b10:   r_req_count <= r_req_count + (REQ_AW + 1)'(1);
                2'b01:   r_req_count <= r_req_count - (REQ_AW + 1)'(1);
                default: r_req_count <= r_req_count;
            endcase
        end
    end

    // ---------------- credit check and issue pipe ----------------
    logic [RSP_AW:0]    r_rsp_count;
    logic               r_s0_v, r_s1_v;
    logic [TAG_W-1:0]   r_s0_tag, r_s1_tag;
    logic [WIDTH-1:0]   r_alu_in_1, r_alu_in_2;
    logic [2:0]         r_alu_op;
    logic [CRD_W-1:0]   w_credit_used;

    // Reserving a response slot for every op in the ALU pipe means a result is never dropped.
    assign w_credit_used = CRD_W'(r_rsp_count) + CRD_W'(r_s0_v) + CRD_W'(r_s1_v);
    assign w_issue       = !w_req_empty && (w_credit_used < CRD_W'(RSP_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_in_1 <= '0;
            r_alu_in_2 <= '0;
            r_alu_op   <= '0;
            r_s0_v     <= 1'b0;
            r_s0_tag   <= '0;
            r_s1_v     <= 1'b0;
            r_s1_tag   <= '0;
        end else begin
            if (w_issue) begin
                {r_alu_op, r_alu_in_1, r_alu_in_2, r_s0_tag} <= w_req_head;
            end
            r_s0_v   <= w_issue;
            r_s1_v   <= r_s0_v;
            r_s1_tag <= r_s0_tag;
        end
    end

    assign alu_in_1 = r_alu_in_1;
    assign alu_in_2 = r_alu_in_2;
    assign alu_op   = r_alu_op;

    // ---------------- response FIFO ----------------
    logic [RSP_W-1:0]  r_rsp_mem [RSP_DEPTH];
    logic [RSP_AW-1:0] r_rsp_wptr, r_rsp_rptr;
    logic              w_rsp_push, w_rsp_pop;

    assign w_rsp_push = r_s1_v;
    assign rsp_valid  = (r_rsp_count != '0);
    assign w_rsp_pop  = rsp_valid && rsp_ready;
    assign {rsp_res, rsp_tag} = rsp_valid ? r_rsp_mem[r_rsp_rptr] : '0;

    always_ff @(posedge clk) begin
        if (w_rsp_push) r_rsp_mem[r_rsp_wptr] <= {alu_res, r_s1_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_wptr  <= '0;
            r_rsp_rptr  <= '0;
            r_rsp_count <= '0;
        end else begin
            if (w_rsp_push) r_rsp_wptr <= r_rsp_wptr + RSP_AW'(1);
            if (w_rsp_pop)  r_rsp_rptr <= r_rsp_rptr + RSP_AW'(1);
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + (RSP_AW + 1)'(1);
                2'b01:   r_rsp_count <= r_rsp_count - (RSP_AW + 1)'(1);
                default: r_rsp_count <= r_rsp_count;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // ---------------- saturating statistics ----------------
    logic [31:0] r_stat_issued, r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_issue && (r_stat_issued != '1)) r_stat_issued <= r_stat_issued + 32'd1;
            if (!w_req_empty && !w_issue && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

endmodule
